// File: rtl/if_stage_if.sv
// Instruction-memory handshake between the fetch stage and a variable-latency imem.
// rdata is only meaningful in a cycle where req && ready.
interface if_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  ready,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ready,
        output rdata
    );
endinterface

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: fetch PC, imem handshake and the IF/ID register.
// Handles decode stalls, downstream redirects and stale in-flight responses.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    if_stage_if.master        imem,
    output logic [31:0]       pc,
    output logic [31:0]       inst,
    output logic              valid
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_pc_next;
    logic [31:0] target_pc;
    logic [31:0] target_pc_next;
    logic [31:0] buf_pc;
    logic [31:0] buf_pc_next;
    logic [31:0] buf_inst;
    logic [31:0] buf_inst_next;
    logic [31:0] pc_next;
    logic [31:0] inst_next;
    logic        valid_next;
    logic        response;
    logic [31:0] redirect_target;

    // Request is gated by rst so it drops asynchronously along with the rest of the stage.
    assign imem.req        = rst && (state != HOLD);
    assign imem.addr       = fetch_pc;
    assign response        = imem.req && imem.ready;
    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= FETCH;
            fetch_pc  <= RESET_PC;
            target_pc <= 32'h0;
            buf_pc    <= 32'h0;
            buf_inst  <= 32'h0;
            pc        <= 32'h0;
            inst      <= 32'h0;
            valid     <= 1'b0;
        end else begin
            state     <= state_next;
            fetch_pc  <= fetch_pc_next;
            target_pc <= target_pc_next;
            buf_pc    <= buf_pc_next;
            buf_inst  <= buf_inst_next;
            pc        <= pc_next;
            inst      <= inst_next;
            valid     <= valid_next;
        end
    end

    always_comb begin
        state_next     = state;
        fetch_pc_next  = fetch_pc;
        target_pc_next = target_pc;
        buf_pc_next    = buf_pc;
        buf_inst_next  = buf_inst;
        pc_next        = pc;
        inst_next      = inst;
        valid_next     = valid;

        if (redirect) begin
            inst_next     = 32'h0;
            valid_next    = 1'b0;
            buf_pc_next   = 32'h0;
            buf_inst_next = 32'h0;
            // An unanswered request cannot be cancelled, so wait for its stale response first.
            if ((state == FETCH || state == DRAIN) && !response) begin
                state_next     = DRAIN;
                target_pc_next = redirect_target;
            end else begin
                state_next    = FETCH;
                fetch_pc_next = redirect_target;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (response) begin
                        fetch_pc_next = fetch_pc + 32'd4;
                        if (stall) begin
                            buf_pc_next   = fetch_pc;
                            buf_inst_next = imem.rdata;
                            state_next    = HOLD;
                        end else begin
                            pc_next    = fetch_pc;
                            inst_next  = imem.rdata;
                            valid_next = 1'b1;
                        end
                    end else if (!stall) begin
                        inst_next  = 32'h0;
                        valid_next = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        pc_next    = buf_pc;
                        inst_next  = buf_inst;
                        valid_next = 1'b1;
                        state_next = FETCH;
                    end
                end
                DRAIN: begin
                    inst_next  = 32'h0;
                    valid_next = 1'b0;
                    if (response) begin
                        fetch_pc_next = target_pc;
                        state_next    = FETCH;
                    end
                end
                default: begin
                    state_next = FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: the expected program-order stream is queued by the
// stimulus process and popped by a monitor whenever decode consumes an instruction.
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_ready;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;

    int checks = 0;
    int failures = 0;
    int consumed = 0;
    logic [31:0] exp_q[$];
    logic [31:0] next_exp;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    if_stage_if bus();
    assign bus.ready = mem_ready;
    assign bus.rdata = mem_word(bus.addr);

    if_stage #(.RESET_PC(RESET_PC)) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .imem(bus),
        .pc(pc),
        .inst(inst),
        .valid(valid)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic top_up();
        while (exp_q.size() < 4) begin
            exp_q.push_back(next_exp);
            next_exp = next_exp + 32'd4;
        end
    endtask

    task automatic apply_stimulus(input logic s, input logic r, input logic [31:0] rp, input logic rdy);
        @(negedge clk);
        stall       = s;
        redirect    = r;
        redirect_pc = rp;
        mem_ready   = rdy;
        if (r) begin
            exp_q.delete();
            next_exp = rp & 32'hFFFF_FFFC;
        end
        top_up();
    endtask

    task automatic release_reset();
        @(negedge clk);
        stall     = 1'b0;
        redirect  = 1'b0;
        mem_ready = 1'b1;
        rst       = 1'b1;
        exp_q.delete();
        next_exp = RESET_PC;
        top_up();
        #1;
        check_bit("first_req", bus.req, 1'b1);
        check_output("first_addr", bus.addr, RESET_PC);
    endtask

    // Monitor: protocol/timing rules on the previous cycle plus in-order scoreboard pops.
    logic        prev_ok = 1'b0;
    logic        stale = 1'b0;
    logic [31:0] stale_target = 32'h0;
    logic        p_req, p_ready, p_stall, p_redirect, p_stale;
    logic [31:0] p_addr, p_target;
    logic        mon_consume;
    logic [31:0] mon_exp;

    always @(negedge clk) begin
        #2;
        if (rst !== 1'b1) begin
            prev_ok = 1'b0;
            stale   = 1'b0;
        end else begin
            mon_consume = valid && !stall && !redirect;
            if (!valid) check_output("bubble_inst", inst, 32'h0);
            if (prev_ok) begin
                if (p_req && !p_ready) begin
                    check_bit("wait_req", bus.req, 1'b1);
                    check_output("wait_addr", bus.addr, p_addr);
                end
                if (p_redirect) begin
                    check_bit("redir_bubble", valid, 1'b0);
                    check_bit("redir_req", bus.req, 1'b1);
                    if (!(p_req && !p_ready)) check_output("redir_addr", bus.addr, p_target);
                end else if (p_req && p_ready) begin
                    if (p_stale) begin
                        check_bit("stale_dropped", valid, 1'b0);
                        check_output("stale_next_addr", bus.addr, stale_target);
                    end else if (!p_stall) begin
                        check_bit("resp_valid", valid, 1'b1);
                        check_output("resp_pc", pc, p_addr);
                        check_output("resp_inst", inst, mem_word(p_addr));
                    end else begin
                        check_bit("hold_req", bus.req, 1'b0);
                    end
                end else if (!p_req) begin
                    if (p_stall) begin
                        check_bit("hold_stays", bus.req, 1'b0);
                    end else begin
                        check_bit("release_valid", valid, 1'b1);
                        check_bit("release_req", bus.req, 1'b1);
                    end
                end
            end
            if (mon_consume) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL sb_empty actual=%h expected=none", pc);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check_output("sb_pc", pc, mon_exp);
                    check_output("sb_inst", inst, mem_word(mon_exp));
                    consumed++;
                end
            end
            p_stale = stale;
            if (redirect) begin
                stale        = bus.req && !mem_ready;
                stale_target = redirect_pc & 32'hFFFF_FFFC;
            end else if (bus.req && mem_ready) begin
                stale = 1'b0;
            end
            p_req      = bus.req;
            p_ready    = mem_ready;
            p_stall    = stall;
            p_redirect = redirect;
            p_addr     = bus.addr;
            p_target   = redirect_pc & 32'hFFFF_FFFC;
            prev_ok    = 1'b1;
        end
    end

    initial begin
        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        mem_ready   = 1'b1;
        next_exp    = RESET_PC;
        #1 rst = 1'b0;
        #12;
        check_output("rst_pc", pc, 32'h0);
        check_output("rst_inst", inst, 32'h0);
        check_bit("rst_valid", valid, 1'b0);
        check_bit("rst_req", bus.req, 1'b0);
        check_output("rst_addr", bus.addr, RESET_PC);

        release_reset();
        repeat (5) apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);

        repeat (3) apply_stimulus(1'b1, 1'b0, 32'h0, 1'b1);
        repeat (3) apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);

        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 32'h0000_4001, 1'b0);
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0);
        repeat (5) apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);

        repeat (2) apply_stimulus(1'b1, 1'b0, 32'h0, 1'b1);
        apply_stimulus(1'b1, 1'b1, 32'h0000_5000, 1'b1);
        repeat (4) apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);

        apply_stimulus(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
        repeat (5) apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            apply_stimulus(($urandom % 100) < 30, ($urandom % 100) < 7,
                           $urandom, ($urandom % 100) < 60);
        end
        repeat (5) apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);

        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0);
        #3 rst = 1'b0;
        #1;
        check_bit("async_req", bus.req, 1'b0);
        check_bit("async_valid", valid, 1'b0);
        check_output("async_inst", inst, 32'h0);
        check_output("async_pc", pc, 32'h0);
        check_output("async_addr", bus.addr, RESET_PC);
        repeat (2) @(negedge clk);
        release_reset();
        repeat (6) apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);

        @(negedge clk);
        #3;
        check_bit("progress", consumed > 200, 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage MIPS pipeline. It holds the fetch PC and drives a variable-latency instruction-memory handshake. It also contains the IF/ID pipeline register that supplies `pc`/`inst` to the decode stage. It honours hazard stalls from decode and PC redirects resolved downstream, discarding wrong-path fetches, and inserts all-zero NOP bubbles whenever it has no valid instruction to present.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address after reset; low 2 bits must be 0.
- `clk` input 1: the single clock; all state on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `stall` input 1: decode hazard hold; when 1 the IF/ID register keeps its value.
- `redirect` input 1: taken branch/jump/jr; flushes IF/ID and changes fetch PC.
- `redirect_pc` input 32: redirect target; bits [1:0] are ignored and forced to 0.
- `imem_req` output 1: fetch request valid.
- `imem_addr` output 32: fetch word address.
- `imem_ready` input 1: response strobe; `imem_rdata` is valid in a cycle where `imem_req && imem_ready`.
- `imem_rdata` input 32: fetched instruction.
- `pc` output 32: IF/ID address of `inst`.
- `inst` output 32: IF/ID instruction; 32'h0 (NOP) when `valid`=0.
- `valid` output 1: IF/ID holds a real instruction.

## Operation
- Registers:
  - `fetch_pc` (drives `imem_addr`).
  - `target_pc`.
  - Buffer `buf_pc`/`buf_inst`.
  - IF/ID `pc`/`inst`/`valid`.
  - 2-bit state.
- States: FETCH, HOLD, DRAIN.
- `imem_req` = 1 in FETCH and DRAIN, 0 in HOLD, 0 while `rst`=0.
- While `imem_req`=1 and `imem_ready`=0, `imem_addr` stays stable.
- A response is `imem_req && imem_ready`.
- Priority, highest first: reset, redirect, response/stall.
- **FETCH, response, `stall`=0:**
  - IF/ID <= {`fetch_pc`, `imem_rdata`, 1}.
  - `fetch_pc` += 4.
  - Stay in FETCH.
- **FETCH, response, `stall`=1:**
  - Buffer <= {`fetch_pc`, `imem_rdata`}.
  - `fetch_pc` += 4.
  - IF/ID holds.
  - Go to HOLD.
- **FETCH, no response:**
  - If `stall`=1, IF/ID holds.
  - Else IF/ID <= bubble {pc unchanged, inst 0, valid 0}.
- **HOLD, `stall`=0:**
  - IF/ID <= {`buf_pc`, `buf_inst`, 1}.
  - Go to FETCH.
- **HOLD, `stall`=1:** hold everything.
- **Redirect (any state):**
  - IF/ID <= bubble; this overrides `stall`.
  - Buffer contents are discarded.
  - If in FETCH with no response that cycle, or already in DRAIN with no response, go to DRAIN with `target_pc` <= {`redirect_pc`[31:2], 2'b00}.
  - Otherwise (response this cycle, or HOLD): `fetch_pc` <= target, go to FETCH; the response data is discarded.
- **DRAIN:**
  - Keeps the stale `imem_addr` until the response arrives.
  - On the response, the data is discarded, `fetch_pc` <= `target_pc`, go to FETCH.
  - IF/ID shows a bubble throughout.
  - A new redirect in DRAIN overwrites `target_pc`.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.

## Timing
- While `rst`=0, asynchronously:
  - `pc`=0, `inst`=0, `valid`=0, `imem_req`=0.
  - `fetch_pc`=`RESET_PC`, `imem_addr`=`RESET_PC`.
  - state=FETCH, buffer cleared.
- The first request appears in the first cycle with `rst`=1.
- Reset mid-request abandons the request. The memory shares `rst` and must drop it too.
- Zero-wait memory (`imem_ready`=1): the instruction fetched in cycle k is on `inst` in cycle k+1. Throughput is 1 per cycle.
- Redirect sampled at edge k:
  - IF/ID holds a bubble in cycle k+1.
  - `imem_addr`=target in cycle k+1.
  - The target instruction is on `inst` in cycle k+2 with zero-wait memory.
- Redirect during an outstanding request: the target is issued in the cycle after the stale response.
- Stall release from HOLD: the buffered instruction appears on the next edge with no extra bubble. The fetch restarts in the same cycle.
- No instruction is lost or duplicated across any stall/redirect combination.

## Test plan
- **Reset sequence:** `RESET_PC`=32'h3000, zero-wait memory returning `addr`, 5 cycles after `rst` release. Expected: `inst` = 3000, 3004, 3008… on consecutive cycles, `valid`=1, `pc`=`inst`.
- **Stall during an in-flight fetch:** `stall`=1 for 3 cycles. Expected:
  - IF/ID frozen at 3004, state HOLD, `imem_req`=0.
  - On release, 3008 appears next cycle, then 300C.
  - No gap or duplicate.
- **Redirect with wait states:**
  - Setup: `imem_ready` delayed 3 cycles; `redirect`=1 with `redirect_pc`=32'h4001 on the 2nd wait cycle.
  - Expected: `imem_addr` holds the old value until ready, the stale data is dropped, the next `imem_addr`=32'h4000, `valid`=0 in between.
- **Simultaneous redirect and stall:**
  - Setup: `redirect`=1 and `stall`=1 while in HOLD.
  - Expected: IF/ID becomes a bubble, the buffer is discarded, the target instruction appears two cycles later with zero-wait memory.
- **Address wrap-around:** `redirect_pc`=32'hFFFF_FFF8. Expected: fetched `pc` = FFFF_FFF8, FFFF_FFFC, 0000_0000.
- **Asynchronous reset mid-request:** assert `rst`=0 between clock edges with `imem_ready`=0. Expected: `imem_req`, `valid` and `inst` drop to 0 immediately; fetch resumes at `RESET_PC` after release.
